alu_issue_stage: RTL and testbench

- ID/EX issue register that drives the execute-stage ALU and consumes its results.
- Decodes RV32I class/funct3/funct7 into the 3-bit ALU control code.
- Selects and registers both ALU operands; applies sign-bias so the ALU's unsigned compare yields signed results.
- Resolves conditional branches from the ALU's EQ/result outputs, with valid/ready upstream, stall/flush control and taken-branch squash.

---
 rtl/alu_issue_pkg.sv | 42 ++++
 rtl/alu_issue_stage_if.sv | 27 ++
 rtl/alu_issue_stage_alu_ctrl_decode.sv | 57 +++++
 rtl/alu_issue_stage.sv | 90 +++++++++
 tb/tb_alu_issue_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types for the ID/EX ALU issue stage: ALU control codes, op classes,
// branch kinds and the decoder's output bundle.
package alu_issue_pkg;

  localparam int unsigned ISSUE_DATA_WIDTH = 32;
  localparam int unsigned ISSUE_PC_WIDTH   = 32;
  localparam int unsigned SIGN_BIAS_BIT    = ISSUE_DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_LTU = 3'b010,
    ALU_SLL = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    CLS_MEM    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_RTYPE  = 2'b10,
    CLS_ITYPE  = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_LT   = 2'b10
  } br_kind_e;

  typedef struct packed {
    alu_ctrl_e alu_ctrl;
    logic      bias;
    br_kind_e  br_kind;
    logic      br_invert;
    logic      unsupported;
    logic      op2_imm;
  } decode_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-issue handshake and instruction payload bundle.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32
);
  logic                  id_valid_i;
  logic                  id_ready_o;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [PC_WIDTH-1:0]   pc_i;
  logic [1:0]            op_class_i;
  logic [2:0]            funct3_i;
  logic                  funct7b5_i;

  modport master (
    output id_valid_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
           op_class_i, funct3_i, funct7b5_i,
    input  id_ready_o
  );

  modport slave (
    input  id_valid_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
           op_class_i, funct3_i, funct7b5_i,
    output id_ready_o
  );
endinterface

// File: rtl/alu_issue_stage_alu_ctrl_decode.sv
// Combinational RV32I class/funct3/funct7b5 decode into ALU control, operand
// bias, branch kind/polarity and the unsupported-SRA flag.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0] op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output decode_t    dec
);

  always_comb begin
    dec = '{alu_ctrl: ALU_ADD, bias: 1'b0, br_kind: BR_NONE,
            br_invert: 1'b0, unsupported: 1'b0, op2_imm: 1'b0};
    unique case (op_class_e'(op_class))
      CLS_MEM: dec.op2_imm = 1'b1;
      CLS_BRANCH: begin
        unique case (funct3)
          3'b000, 3'b001: begin
            dec.alu_ctrl  = ALU_SUB;
            dec.br_kind   = BR_EQ;
            dec.br_invert = funct3[0];
          end
          3'b100, 3'b101, 3'b110, 3'b111: begin
            dec.alu_ctrl  = ALU_LTU;
            dec.br_kind   = BR_LT;
            dec.br_invert = funct3[0];
            dec.bias      = ~funct3[1];
          end
          default: ;
        endcase
      end
      CLS_RTYPE, CLS_ITYPE: begin
        dec.op2_imm = (op_class_e'(op_class) == CLS_ITYPE);
        unique case (funct3)
          3'b000: if (op_class_e'(op_class) == CLS_RTYPE && funct7b5) dec.alu_ctrl = ALU_SUB;
          3'b001: dec.alu_ctrl = ALU_SLL;
          3'b010: begin
            dec.alu_ctrl = ALU_LTU;
            dec.bias     = 1'b1;
          end
          3'b011: dec.alu_ctrl = ALU_LTU;
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            // Arithmetic right shift is issued as a logical shift and flagged.
            dec.alu_ctrl    = ALU_SRL;
            dec.unsupported = funct7b5;
          end
          3'b110: dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: registers ALU operands/control, resolves conditional
// branches from the ALU's flags, with stall/flush and taken-branch squash.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_stage_if.slave      id,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] alu_op1_o,
  output logic [DATA_WIDTH-1:0] alu_op2_o,
  output logic [2:0]            alu_ctrl_o,
  input  logic [DATA_WIDTH-1:0] alu_out_i,
  input  logic                  alu_eq_i,
  output logic                  ex_valid_o,
  output logic [PC_WIDTH-1:0]   ex_pc_o,
  output logic                  branch_taken_o,
  output logic                  unsupported_o
);

  // Flipping the MSB of both operands maps signed order onto unsigned order.
  localparam logic [DATA_WIDTH-1:0] BIAS_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  decode_t               dec;
  logic [DATA_WIDTH-1:0] bias_mask;
  logic [DATA_WIDTH-1:0] op1_d;
  logic [DATA_WIDTH-1:0] op2_d;
  br_kind_e              br_kind_q;
  logic                  br_invert_q;
  logic                  lt_flag;

  alu_ctrl_decode u_decode (
    .op_class (id.op_class_i),
    .funct3   (id.funct3_i),
    .funct7b5 (id.funct7b5_i),
    .dec      (dec)
  );

  assign bias_mask = dec.bias ? BIAS_MASK : '0;
  assign op1_d     = id.rs1_data_i ^ bias_mask;
  assign op2_d     = (dec.op2_imm ? id.imm_i : id.rs2_data_i) ^ bias_mask;

  // LTU yields exactly 0 or 1, so any set bit means less-than.
  assign lt_flag = (alu_out_i != '0);

  always_comb begin
    branch_taken_o = 1'b0;
    case (br_kind_q)
      BR_EQ:   branch_taken_o = ex_valid_o & (alu_eq_i ^ br_invert_q);
      BR_LT:   branch_taken_o = ex_valid_o & (lt_flag ^ br_invert_q);
      default: branch_taken_o = 1'b0;
    endcase
  end

  assign id.id_ready_o = !stall_i && !flush_i && !branch_taken_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_o    <= 1'b0;
      alu_op1_o     <= '0;
      alu_op2_o     <= '0;
      alu_ctrl_o    <= '0;
      ex_pc_o       <= '0;
      unsupported_o <= 1'b0;
      br_kind_q     <= BR_NONE;
      br_invert_q   <= 1'b0;
    end else if (flush_i || branch_taken_o) begin
      ex_valid_o    <= 1'b0;
      unsupported_o <= 1'b0;
    end else if (!stall_i) begin
      ex_valid_o <= id.id_valid_i;
      if (id.id_valid_i) begin
        alu_op1_o     <= op1_d;
        alu_op2_o     <= op2_d;
        alu_ctrl_o    <= dec.alu_ctrl;
        ex_pc_o       <= id.pc_i;
        unsupported_o <= dec.unsupported;
        br_kind_q     <= dec.br_kind;
        br_invert_q   <= dec.br_invert;
      end else begin
        unsupported_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed plan steps then randomized traffic,
// checked against an instruction-level reference model and a behavioural ALU.
module tb_alu_issue_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush;
  logic [DW-1:0] op1, op2, alu_out;
  logic [2:0]    ctrl;
  logic          alu_eq, ex_valid, taken, unsup;
  logic [PW-1:0] ex_pc;

  int tests = 0;
  int fails = 0;

  // Reference state: the raw instruction currently in EX.
  logic          m_valid;
  logic [1:0]    m_cls;
  logic [2:0]    m_f3;
  logic          m_f7;
  logic [DW-1:0] m_rs1, m_rs2, m_imm;
  logic [PW-1:0] m_pc;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) id_bus ();

  alu_issue_stage #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id             (id_bus.slave),
    .stall_i        (stall),
    .flush_i        (flush),
    .alu_op1_o      (op1),
    .alu_op2_o      (op2),
    .alu_ctrl_o     (ctrl),
    .alu_out_i      (alu_out),
    .alu_eq_i       (alu_eq),
    .ex_valid_o     (ex_valid),
    .ex_pc_o        (ex_pc),
    .branch_taken_o (taken),
    .unsupported_o  (unsup)
  );

  // Execute-stage ALU stand-in.
  always_comb begin
    alu_eq = (op1 == op2);
    case (ctrl)
      3'b000:  alu_out = op1 + op2;
      3'b001:  alu_out = op1 - op2;
      3'b010:  alu_out = (op1 < op2) ? 32'd1 : 32'd0;
      3'b011:  alu_out = op1 << op2[4:0];
      3'b100:  alu_out = op1 ^ op2;
      3'b101:  alu_out = op1 >> op2[4:0];
      3'b110:  alu_out = op1 | op2;
      default: alu_out = op1 & op2;
    endcase
  end

  function automatic logic [2:0] exp_ctrl(logic [1:0] cls, logic [2:0] f3, logic f7);
    if (cls == 2'd0) return 3'b000;
    if (cls == 2'd1) begin
      if (f3 == 3'd0 || f3 == 3'd1) return 3'b001;
      if (f3 >= 3'd4) return 3'b010;
      return 3'b000;
    end
    case (f3)
      3'd0:    return (cls == 2'd2 && f7) ? 3'b001 : 3'b000;
      3'd1:    return 3'b011;
      3'd2:    return 3'b010;
      3'd3:    return 3'b010;
      default: return f3;
    endcase
  endfunction

  function automatic bit is_signed_cmp(logic [1:0] cls, logic [2:0] f3);
    return (cls == 2'd1 && (f3 == 3'd4 || f3 == 3'd5)) || (cls >= 2'd2 && f3 == 3'd2);
  endfunction

  function automatic logic [DW-1:0] exp_op1(logic [1:0] cls, logic [2:0] f3, logic [DW-1:0] rs1);
    return is_signed_cmp(cls, f3) ? (rs1 ^ 32'h8000_0000) : rs1;
  endfunction

  function automatic logic [DW-1:0] exp_op2(logic [1:0] cls, logic [2:0] f3,
                                            logic [DW-1:0] rs2, logic [DW-1:0] imm);
    logic [DW-1:0] v;
    v = (cls == 2'd0 || cls == 2'd3) ? imm : rs2;
    return is_signed_cmp(cls, f3) ? (v ^ 32'h8000_0000) : v;
  endfunction

  function automatic bit exp_br(logic [1:0] cls, logic [2:0] f3, logic [DW-1:0] a, logic [DW-1:0] b);
    if (cls != 2'd1) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_unsup(logic [1:0] cls, logic [2:0] f3, logic f7);
    return cls >= 2'd2 && f3 == 3'd5 && f7;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                       input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                       input logic [DW-1:0] imm, input logic [PW-1:0] pc);
    id_bus.id_valid_i = v;
    id_bus.op_class_i = cls;
    id_bus.funct3_i   = f3;
    id_bus.funct7b5_i = f7;
    id_bus.rs1_data_i = rs1;
    id_bus.rs2_data_i = rs2;
    id_bus.imm_i      = imm;
    id_bus.pc_i       = pc;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_cls = '0; m_f3 = '0; m_f7 = 1'b0;
    m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_pc = '0;
  endtask

  // Check all outputs against the model for the current inputs, then advance one edge.
  task automatic cycle();
    bit et, er;
    #1;
    et = m_valid && exp_br(m_cls, m_f3, m_rs1, m_rs2);
    er = !stall && !flush && !et;
    check("ex_valid",     64'(ex_valid), 64'(m_valid));
    check("branch_taken", 64'(taken), 64'(et));
    check("id_ready",     64'(id_bus.id_ready_o), 64'(er));
    check("unsupported",  64'(unsup), 64'(m_valid && exp_unsup(m_cls, m_f3, m_f7)));
    check("alu_op1",      64'(op1), 64'(exp_op1(m_cls, m_f3, m_rs1)));
    check("alu_op2",      64'(op2), 64'(exp_op2(m_cls, m_f3, m_rs2, m_imm)));
    check("alu_ctrl",     64'(ctrl), 64'(exp_ctrl(m_cls, m_f3, m_f7)));
    check("ex_pc",        64'(ex_pc), 64'(m_pc));
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (flush || et) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = id_bus.id_valid_i;
      if (id_bus.id_valid_i) begin
        m_cls = id_bus.op_class_i; m_f3 = id_bus.funct3_i; m_f7 = id_bus.funct7b5_i;
        m_rs1 = id_bus.rs1_data_i; m_rs2 = id_bus.rs2_data_i;
        m_imm = id_bus.imm_i;      m_pc  = id_bus.pc_i;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] r1, r2;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 2'd2, 3'd0, 1'b0, 32'd7, 32'd9, 32'd1, 32'h100);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();

    rst_n = 1'b1;
    drive(1'b1, 2'd2, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'h200);       // SUB
    cycle();
    drive(1'b1, 2'd1, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h204); // BLT
    cycle();
    drive(1'b1, 2'd1, 3'd1, 1'b0, 32'd5, 32'd5, 32'd0, 32'h208);         // BNE not taken
    cycle();
    cycle();
    drive(1'b1, 2'd1, 3'd1, 1'b0, 32'd5, 32'd6, 32'd0, 32'h20C);         // BNE taken
    cycle();
    drive(1'b0, 2'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h0);
    cycle();
    drive(1'b1, 2'd3, 3'd5, 1'b1, 32'hF000_0000, 32'd0, 32'd4, 32'h210); // SRAI
    cycle();
    stall = 1'b1;
    drive(1'b1, 2'd2, 3'd6, 1'b0, 32'd1, 32'd2, 32'd0, 32'h214);
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 2'd3, 3'd3, 1'b0, 32'h8000_0000, 32'd0, 32'd1, 32'h218); // SLTIU
    cycle();
    cycle();

    for (int i = 0; i < 600; i++) begin
      r1 = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), r1, r2, $urandom, $urandom);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      cycle();
    end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
